// File: rtl/control_sequencer_if.sv
// Handshake and status bundle between a fetch/flag source and control_sequencer.
// The sequencer uses the slave modport; the fetch/flag source uses the master modport.
interface control_sequencer_if #(
    parameter int INSTR_W = 16,
    parameter int STEP_W  = 3
);
    logic [INSTR_W-1:0] instr_in;
    logic               mem_ready;
    logic [3:0]         status_reg;
    logic               stall;
    logic               resume;
    logic [2:0]         phase;
    logic [STEP_W-1:0]  step;
    logic [INSTR_W-1:0] instr_q;
    logic               fetch_req;
    logic               done;
    logic               illegal;
    logic               cond_taken;

    modport slave (
        input  instr_in, mem_ready, status_reg, stall, resume,
        output phase, step, instr_q, fetch_req, done, illegal, cond_taken
    );

    modport master (
        output instr_in, mem_ready, status_reg, stall, resume,
        input  phase, step, instr_q, fetch_req, done, illegal, cond_taken
    );
endinterface

// File: rtl/control_sequencer.sv
// Instruction control sequencer: FETCH -> LOAD -> DECODE -> EXEC (micro-steps) or HALT.
// Define SEQ_COND_BR_EN to enable BRNE (0x7) and BRC (0xE); otherwise both opcodes are illegal.
module control_sequencer #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int STEP_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.slave   bus
);
    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_LOAD   = 3'd1;
    localparam logic [2:0] PH_DECODE = 3'd2;
    localparam logic [2:0] PH_EXEC   = 3'd3;
    localparam logic [2:0] PH_HALT   = 3'd4;

    localparam int MAX_LEN = 6;

    if (OPC_W < 4) begin : g_bad_opc_w
        $error("control_sequencer: OPC_W must be at least 4");
    end
    if (INSTR_W < OPC_W) begin : g_bad_instr_w
        $error("control_sequencer: INSTR_W must be at least OPC_W");
    end
    if (STEP_W < 3) begin : g_bad_step_w
        $error("control_sequencer: STEP_W must be at least 3");
    end
    if (MAX_LEN > (1 << STEP_W)) begin : g_bad_step_range
        $error("control_sequencer: STEP_W too narrow for the longest instruction");
    end

    logic [2:0]         r_phase;
    logic [STEP_W-1:0]  r_step;
    logic [STEP_W-1:0]  r_last;
    logic [INSTR_W-1:0] r_instr_q;
    logic               r_cond_taken;

    logic [OPC_W-1:0]   w_opc;
    logic [3:0]         w_opc_lo;
    logic               w_opc_hi_zero;
    logic               w_flag_z;
    logic               w_flag_c;
    logic               w_known;
    logic               w_halt;
    logic               w_cond;
    logic               w_cond_hit;
    logic [STEP_W-1:0]  w_last;
    logic               w_step_at_last;
    logic               w_done;
    logic               w_illegal;

    function automatic logic [STEP_W-1:0] last_of(input int len);
        return STEP_W'(len - 1);
    endfunction

    assign w_opc         = r_instr_q[INSTR_W-1 -: OPC_W];
    assign w_opc_lo      = w_opc[3:0];
    assign w_opc_hi_zero = ((w_opc >> 4) == '0);
    assign w_flag_z      = bus.status_reg[1];
    assign w_flag_c      = bus.status_reg[2];

    // Opcode table: length of EXEC (as last step index) and the branch condition.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        w_known    = 1'b1;
        w_halt     = 1'b0;
        w_cond     = 1'b0;
        w_cond_hit = 1'b0;
        w_last     = last_of(1);
        case (w_opc_lo)
            4'h0, 4'h1, 4'h5, 4'h6: w_last = last_of(1);
            4'h2, 4'h3, 4'h4:       w_last = last_of(3);
            4'h8, 4'h9, 4'hB:       w_last = last_of(4);
            4'hA:                   w_last = last_of(6);
            4'hC:                   w_last = last_of(2);
            4'hD: begin
                w_cond     = 1'b1;
                w_cond_hit = w_flag_z;
            end
`ifdef SEQ_COND_BR_EN
            4'h7: begin
                w_cond     = 1'b1;
                w_cond_hit = ~w_flag_z;
            end
            4'hE: begin
                w_cond     = 1'b1;
                w_cond_hit = w_flag_c;
            end
`endif
            4'hF:    w_halt  = 1'b1;
            default: w_known = 1'b0;
        endcase
        if (w_cond) begin
            w_last = w_cond_hit ? last_of(4) : last_of(2);
        end
        if (!w_opc_hi_zero) begin
            w_known = 1'b0;
            w_halt  = 1'b0;
            w_cond  = 1'b0;
        end
    end

    assign w_step_at_last = (r_step == r_last);
    assign w_done         = (r_phase == PH_EXEC) && !bus.stall && w_step_at_last;
    assign w_illegal      = (r_phase == PH_DECODE) && !w_known;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase      <= PH_FETCH;
            r_step       <= '0;
            r_last       <= '0;
            r_instr_q    <= '0;
            r_cond_taken <= 1'b0;
        end else begin
            case (r_phase)
                PH_FETCH: begin
                    if (bus.mem_ready) begin
                        r_instr_q <= bus.instr_in;
                        r_phase   <= PH_LOAD;
                    end
                end
                PH_LOAD: r_phase <= PH_DECODE;
                PH_DECODE: begin
                    // Flags are sampled only here, so later flag changes cannot alter the branch.
                    r_cond_taken <= w_known && w_cond && w_cond_hit;
                    r_last       <= w_last;
                    r_step       <= '0;
                    if (!w_known) begin
                        r_phase <= PH_FETCH;
                    end else if (w_halt) begin
                        r_phase <= PH_HALT;
                    end else begin
                        r_phase <= PH_EXEC;
                    end
                end
                PH_EXEC: begin
                    if (!bus.stall) begin
                        if (w_step_at_last) begin
                            r_phase <= PH_FETCH;
                            r_step  <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                PH_HALT: begin
                    if (bus.resume) begin
                        r_phase <= PH_FETCH;
                    end
                end
                default: r_phase <= PH_FETCH;
            endcase
        end
    end

    assign bus.phase      = r_phase;
    assign bus.step       = r_step;
    assign bus.instr_q    = r_instr_q;
    assign bus.fetch_req  = (r_phase == PH_FETCH);
    assign bus.done       = w_done;
    assign bus.illegal    = w_illegal;
    assign bus.cond_taken = r_cond_taken;

    a_step_in_range: assert property (@(posedge clk) disable iff (reset)
        (r_phase == PH_EXEC) |-> (r_step <= r_last));
    a_step_idle_zero: assert property (@(posedge clk) disable iff (reset)
        (r_phase != PH_EXEC) |-> (r_step == '0));
    a_done_only_exec: assert property (@(posedge clk) disable iff (reset)
        bus.done |-> (r_phase == PH_EXEC));
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: phase sequencing, EXEC lengths, branches, stall, HALT, reset.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    control_sequencer_if #(.INSTR_W(16), .STEP_W(3)) bus ();

    control_sequencer #(.INSTR_W(16), .OPC_W(4), .STEP_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] ins;
        int          len;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From a FETCH negedge: present one word, walk through LOAD, stop at the DECODE negedge.
    task automatic fetch_and_decode(input string tag, input logic [15:0] ins);
        check({tag, " in fetch"}, bus.phase, 0);
        bus.instr_in  = ins;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check({tag, " load"}, bus.phase, 1);
        check({tag, " instr_q"}, bus.instr_q, ins);
        tick();
        check({tag, " decode"}, bus.phase, 2);
    endtask

    // From the first EXEC negedge: count EXEC cycles and done pulses, optional Z toggling and step-2 stall.
    task automatic run_exec(input string tag, input bit toggle_z, input int stall_len,
                            output int cycles, output int dones, output int done_idx);
        int held;
        held     = 0;
        cycles   = 0;
        dones    = 0;
        done_idx = -1;
        for (int g = 0; g < 64; g++) begin
            if (bus.phase != 3'd3) break;
            if (bus.done) begin
                dones++;
                done_idx = cycles;
            end
            if (toggle_z) bus.status_reg[1] = ~bus.status_reg[1];
            if (stall_len > 0 && bus.step == 3'd2 && held < stall_len) begin
                bus.stall = 1'b1;
                held++;
            end else begin
                bus.stall = 1'b0;
            end
            cycles++;
            tick();
        end
        bus.stall = 1'b0;
        check({tag, " exit to fetch"}, bus.phase, 0);
    endtask

    task automatic exec_case(input string tag, input logic [15:0] ins, input int exp_len,
                             input bit toggle_z, input int stall_len);
        int cycles, dones, done_idx;
        fetch_and_decode(tag, ins);
        check({tag, " no illegal"}, bus.illegal, 0);
        tick();
        check({tag, " exec entry"}, bus.phase, 3);
        run_exec(tag, toggle_z, stall_len, cycles, dones, done_idx);
        check({tag, " exec cycles"}, cycles, exp_len);
        check({tag, " done count"}, dones, 1);
        check({tag, " done on last"}, done_idx, exp_len - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t1_phase[7] = '{0, 1, 2, 3, 3, 3, 0};
        int   t1_step[7]  = '{0, 0, 0, 0, 1, 2, 0};
        int   t1_done[7]  = '{0, 0, 0, 0, 0, 1, 0};
        vec_t vecs[6]     = '{'{16'h0000, 1}, '{16'h5000, 1}, '{16'h8000, 4},
                              '{16'hC000, 2}, '{16'hB000, 4}, '{16'h3000, 3}};
        int   halt_dones;
        int   halt_fetch;

        reset          = 1'b1;
        bus.instr_in   = '0;
        bus.mem_ready  = 1'b0;
        bus.status_reg = 4'h0;
        bus.stall      = 1'b0;
        bus.resume     = 1'b0;
        tick();
        tick();
        check("rst phase", bus.phase, 0);
        check("rst step", bus.step, 0);
        check("rst instr_q", bus.instr_q, 0);
        check("rst cond_taken", bus.cond_taken, 0);
        check("rst done", bus.done, 0);
        check("rst illegal", bus.illegal, 0);
        reset = 1'b0;
        tick();
        check("post-rst fetch_req", bus.fetch_req, 1);
        check("post-rst phase", bus.phase, 0);

        // ADD with mem_ready held high: fetch-to-fetch in six cycles.
        bus.instr_in  = 16'h2123;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("add phase[%0d]", i), bus.phase, t1_phase[i]);
            check($sformatf("add step[%0d]", i), bus.step, t1_step[i]);
            check($sformatf("add done[%0d]", i), bus.done, t1_done[i]);
            if (i == 6) bus.mem_ready = 1'b0;
            else tick();
        end

        for (int i = 0; i < 6; i++) begin
            exec_case($sformatf("len[%0h]", vecs[i].ins), vecs[i].ins, vecs[i].len, 1'b0, 0);
        end

        // BREQ taken and not taken, Z toggled throughout EXEC.
        bus.status_reg = 4'b0010;
        exec_case("breq taken", 16'hD000, 4, 1'b1, 0);
        check("breq taken cond", bus.cond_taken, 1);
        bus.status_reg = 4'b0000;
        exec_case("breq not taken", 16'hD000, 2, 1'b1, 0);
        check("breq not taken cond", bus.cond_taken, 0);

        // FETCH waits for mem_ready.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait fetch_req[%0d]", i), bus.fetch_req, 1);
            check($sformatf("wait phase[%0d]", i), bus.phase, 0);
            tick();
        end

        // CALL stalled at step 2 for three cycles: nine EXEC cycles.
        exec_case("call stall", 16'hA000, 9, 1'b0, 3);
        check("call cond cleared", bus.cond_taken, 0);

        // HALT holds, ignores stall, then resume returns to FETCH next cycle.
        fetch_and_decode("halt", 16'hF000);
        tick();
        halt_dones = 0;
        halt_fetch = 0;
        bus.stall  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("halt phase[%0d]", i), bus.phase, 4);
            if (bus.done) halt_dones++;
            if (bus.fetch_req) halt_fetch++;
            tick();
        end
        bus.stall = 1'b0;
        check("halt done count", halt_dones, 0);
        check("halt fetch_req count", halt_fetch, 0);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume to fetch", bus.phase, 0);

        // BRNE and BRC depend on the build option; with flags all zero BRNE is taken and BRC is not.
        bus.status_reg = 4'b0000;
`ifdef SEQ_COND_BR_EN
        exec_case("brne", 16'h7000, 4, 1'b0, 0);
        check("brne cond", bus.cond_taken, 1);
        exec_case("brc", 16'hE000, 2, 1'b0, 0);
        check("brc cond", bus.cond_taken, 0);
`else
        fetch_and_decode("brne", 16'h7000);
        check("brne illegal", bus.illegal, 1);
        tick();
        check("brne back to fetch", bus.phase, 0);
        check("brne illegal one cycle", bus.illegal, 0);
        fetch_and_decode("brc", 16'hE000);
        check("brc illegal", bus.illegal, 1);
        tick();
        check("brc back to fetch", bus.phase, 0);
        check("brc illegal one cycle", bus.illegal, 0);
`endif

        // Reset mid-PUSH at step 2 takes effect without a clock edge.
        fetch_and_decode("push", 16'h8123);
        tick();
        tick();
        tick();
        check("push at step 2", bus.step, 2);
        reset = 1'b1;
        #1;
        check("mid rst phase", bus.phase, 0);
        check("mid rst step", bus.step, 0);
        check("mid rst instr_q", bus.instr_q, 0);
        check("mid rst cond_taken", bus.cond_taken, 0);
        check("mid rst done", bus.done, 0);
        check("mid rst illegal", bus.illegal, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("restart fetch_req", bus.fetch_req, 1);
        check("restart phase", bus.phase, 0);
        bus.instr_in  = 16'h1000;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check("restart load", bus.phase, 1);
        check("restart instr_q", bus.instr_q, 16'h1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter INSTR_W, default 16: instruction width.
REQ-002 Parameter OPC_W, default 4, minimum 4: opcode field width; opcode = instr_q[INSTR_W-1 -: OPC_W].
REQ-003 Parameter STEP_W, default 3: micro-step counter width, minimum 3.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 instr_in  in  INSTR_W  fetched instruction word, valid while mem_ready=1.
REQ-007 mem_ready  in  1  fetch data valid handshake.
REQ-008 status_reg  in  4  flags: [3]=N, [2]=C, [1]=Z, [0]=V.
REQ-009 stall  in  1  freezes EXEC progress.
REQ-010 resume  in  1  leaves HALT.
REQ-011 phase  out  3  FETCH=0, LOAD=1, DECODE=2, EXEC=3, HALT=4.
REQ-012 step  out  STEP_W  current micro-step within EXEC; 0 in all other phases.
REQ-013 instr_q  out  INSTR_W  latched instruction.
REQ-014 fetch_req  out  1  high throughout FETCH.
REQ-015 done  out  1  one-cycle pulse on instruction retire.
REQ-016 illegal  out  1  one-cycle pulse on undefined opcode.
REQ-017 cond_taken  out  1  latched branch decision of current instruction.

Function
REQ-018 FETCH: assert fetch_req; go to LOAD on the edge where mem_ready=1; otherwise hold.
REQ-019 LOAD: instr_q <= instr_in as captured on the FETCH->LOAD edge; LOAD always lasts one cycle, then DECODE.
REQ-020 DECODE: one cycle; sample status_reg into cond_taken for conditional opcodes, clear it otherwise; go to EXEC with step=0, or to HALT for opcode 0xF, or pulse illegal and go to FETCH for undefined opcodes.
REQ-021 EXEC lengths (steps 0..L-1): 0x0 LD 1, 0x1 MOV 1, 0x2 ADD 3, 0x3 SUB 3, 0x4 XOR 3, 0x5 LDPC 1, 0x6 BR 1, 0x8 PUSH 4, 0x9 POP 4, 0xA CALL 6, 0xB RET 4, 0xC CMP 2.
REQ-022 Conditional opcodes: 0xD BREQ (Z=1), 0x7 BRNE (Z=0), 0xE BRC (C=1); L=4 when taken, L=2 when not taken.
REQ-023 EXEC: step increments by 1 each cycle with stall=0; at step=L-1 with stall=0, done pulses and phase goes to FETCH.
REQ-024 stall=1 in EXEC holds phase and step, and suppresses done; stall is ignored in all other phases.
REQ-025 HALT: outputs quiescent, done=0; resume=1 moves to FETCH next cycle.
REQ-026 Opcodes >= 16 (OPC_W>4) are undefined.
REQ-027 Flags changing during EXEC do not alter cond_taken or L.
REQ-028 Step counter never wraps; an L > 2^STEP_W is a parameter error flagged by an elaboration-time check.

Reset
REQ-029 reset=1 forces phase=FETCH, step=0, instr_q=0, cond_taken=0, done=0, illegal=0 immediately, including mid-EXEC and in HALT; fetch_req=1 after release.

Configuration
REQ-030 Macro SEQ_COND_BR_EN: defined -> BRNE (0x7) and BRC (0xE) behave per REQ-022; undefined -> 0x7 and 0xE are undefined opcodes (illegal pulse, no EXEC); BREQ is unaffected.

Verification
REQ-031 instr 0x2123, mem_ready held 1 -> phases 0,1,2,3,3,3,0; done pulses on the last EXEC cycle; fetch-to-fetch = 6 cycles.
REQ-032 instr 0xD000 with Z=1 -> 4 EXEC cycles, cond_taken=1; with Z=0 -> 2 EXEC cycles, cond_taken=0; toggling Z during EXEC has no effect.
REQ-033 mem_ready low 5 cycles in FETCH -> fetch_req stays 1, phase stays 0; CALL 0xA000 with stall=1 at step 2 for 3 cycles -> step holds at 2 and EXEC spans 9 cycles.
REQ-034 instr 0xF000 -> HALT held 10 cycles, no done; resume=1 -> FETCH next cycle.
REQ-035 instr 0x7000 -> with SEQ_COND_BR_EN, EXEC runs; without it, illegal pulses once and phase returns to 0 after DECODE.
REQ-036 reset asserted mid-PUSH at step 2 -> all outputs at reset values within the same cycle; fetch restarts after release.
